// File: rtl/shift_acc.sv
// ---------------------------------------------------------------------------
// shift_acc -- bit-serial shift-accumulator at the output end of the DCIM
// adder tree.
//
// It takes one adder-tree partial sum per input-bit plane, MSB plane first.
// Each plane is weighted by its binary position, and the planes are combined
// into the final multiply-accumulate result. In signed mode (sus=1) the MSB
// plane carries negative weight, as in two's complement.
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   start      in   1          begin an operation (honoured only when idle)
//   sus        in   1          mode, captured with start: 0 unsigned, 1 signed
//   in_valid   in   1          psum beat valid (honoured only while busy)
//   psum       in   IN_WIDTH   partial sum for the current bit plane
//   busy       out  1          an operation is accumulating
//   out_valid  out  1          one-cycle pulse: result is newly valid
//   result     out  OUT_WIDTH  last completed result, held until the next one
// ---------------------------------------------------------------------------
module shift_acc #(
  parameter int IN_WIDTH  = 13,
  parameter int NBITS     = 8,
  parameter int OUT_WIDTH = IN_WIDTH + NBITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sus,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  psum,
  output logic                 busy,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] result
);

  localparam int EXT_W = OUT_WIDTH - IN_WIDTH;
  localparam int CNT_W = (NBITS > 2) ? $clog2(NBITS) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sus_q, sus_d;
  logic                   busy_q, busy_d;
  logic                   out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0]   result_q, result_d;

  logic [OUT_WIDTH-1:0]   ext_s;
  logic [OUT_WIDTH-1:0]   beat_s;

  // Operand extension and the accumulator value one accepted beat would produce.
  always_comb begin
    ext_s  = {{EXT_W{1'b0}}, psum};
    beat_s = acc_q;
    if (sus_q) begin
      ext_s = {{EXT_W{psum[IN_WIDTH-1]}}, psum};
    end else begin
      ext_s = {{EXT_W{1'b0}}, psum};
    end
    if (cnt_q == CNT_ZERO) begin
      // MSB plane: its weight is negative in two's-complement mode.
      if (sus_q) begin
        beat_s = -ext_s;
      end else begin
        beat_s = ext_s;
      end
    end else begin
      beat_s = (acc_q << 1) + ext_s;
    end
  end

  // Next-state, accumulator and output logic.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sus_d       = sus_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sus_d   = sus;
          acc_d   = {OUT_WIDTH{1'b0}};
          cnt_d   = CNT_ZERO;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_d = beat_s;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            // The last plane lands straight in result. The machine is idle
            // again, so a new start can be taken in the out_valid cycle.
            result_d    = beat_s;
            out_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == ACC);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= {OUT_WIDTH{1'b0}};
      cnt_q       <= CNT_ZERO;
      sus_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= {OUT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sus_q       <= sus_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule

// File: tb/tb_shift_acc.sv
// Directed bench for shift_acc. A plane-weighting model builds the expected
// busy/out_valid/result, and one compare process checks them on every falling
// edge. Literal results pin both the DUT and the model.
module tb_shift_acc;

  localparam int IW = 13;
  localparam int NB = 8;
  localparam int OW = IW + NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sus = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] psum = '0;
  logic          busy;
  logic          out_valid;
  logic [OW-1:0] result;

  shift_acc #(.IN_WIDTH(IW), .NBITS(NB), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sus(sus), .in_valid(in_valid),
    .psum(psum), .busy(busy), .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b1;

  // Model of the operation: active flag, mode and accepted planes.
  bit            m_active = 1'b0;
  bit            m_signed = 1'b0;
  logic [IW-1:0] beats[$];
  logic          exp_busy = 1'b0;
  logic          exp_ov = 1'b0;
  logic [OW-1:0] exp_result = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // Sum of plane_i * 2^(NB-1-i), with plane 0 negative in signed mode.
  function automatic logic [OW-1:0] weigh();
    longint acc = 0;
    longint v;
    longint w;
    for (int i = 0; i < NB; i++) begin
      w = longint'(1) << (NB - 1 - i);
      if (m_signed) v = longint'($signed(beats[i]));
      else          v = longint'(beats[i]);
      if (m_signed && i == 0) acc = acc - w * v;
      else                    acc = acc + w * v;
    end
    return OW'(acc);
  endfunction

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    logic s, sm, iv;
    logic [IW-1:0] p;
    s = start; sm = sus; iv = in_valid; p = psum;
    @(posedge clk);
    #1;
    exp_ov = 1'b0;
    if (!m_active) begin
      if (s) begin
        m_active = 1'b1;
        m_signed = sm;
        beats.delete();
      end
    end else if (iv) begin
      beats.push_back(p);
      if (beats.size() == NB) begin
        exp_result = weigh();
        exp_ov     = 1'b1;
        m_active   = 1'b0;
      end
    end
    exp_busy = m_active;
  endtask

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", busy, exp_busy);
      chk("out_valid", out_valid, exp_ov);
      chk("result", result, exp_result);
      chk("ov_while_busy", out_valid & busy, 1'b0);
    end
  end

  // One operation: start (with a junk beat that must be ignored), then NB
  // beats of p, optional bubbles before beat index bub_at, optional glitching
  // of start/sus while accumulating. Stops after n_beats beats.
  task automatic run_op(input logic m, input logic [IW-1:0] p, input int bub_at,
                        input int bub_n, input bit glitch, input int n_beats);
    start = 1'b1; sus = m; in_valid = 1'b1; psum = 13'h0AA;
    tick();
    start = 1'b0; sus = glitch ? ~m : m;
    for (int i = 0; i < n_beats; i++) begin
      if (i == bub_at) begin
        for (int b = 0; b < bub_n; b++) begin
          in_valid = 1'b0; psum = 13'h155; start = glitch; sus = ~m;
          tick();
        end
      end
      in_valid = 1'b1; psum = p; start = glitch; sus = glitch ? ~m : m;
      tick();
    end
    in_valid = 1'b0; start = 1'b0; psum = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_result", result, 21'd0);
    #10 rst_n = 1'b1;
    idle(2);

    run_op(1'b0, 13'd1, -1, 0, 1'b0, NB);
    chk("lit_u1", result, 21'd255);   chk("mdl_u1", exp_result, 21'd255);
    chk("pulse_u1", out_valid, 1'b1);
    idle(1);
    run_op(1'b1, 13'd1, -1, 0, 1'b0, NB);
    chk("lit_s1", result, 21'h1FFFFF); chk("mdl_s1", exp_result, 21'h1FFFFF);
    run_op(1'b1, 13'h1FFF, -1, 0, 1'b0, NB);   // back-to-back start
    chk("lit_sm1", result, 21'd1);    chk("mdl_sm1", exp_result, 21'd1);
    run_op(1'b1, 13'h1000, -1, 0, 1'b0, NB);
    chk("lit_smin", result, 21'd4096); chk("mdl_smin", exp_result, 21'd4096);
    run_op(1'b0, 13'h1FFF, -1, 0, 1'b0, NB);
    chk("lit_umax", result, 21'd2088705); chk("mdl_umax", exp_result, 21'd2088705);
    idle(2);
    chk("held_umax", result, 21'd2088705);
    // Bubbles between beats 3 and 4, with start/sus glitching.
    run_op(1'b0, 13'd3, 3, 2, 1'b1, NB);
    chk("lit_bub", result, 21'd765);  chk("mdl_bub", exp_result, 21'd765);
    idle(1);
    run_op(1'b1, 13'd5, 1, 3, 1'b1, NB);
    chk("lit_sglitch", result, 21'h1FFFFB); chk("mdl_sglitch", exp_result, 21'h1FFFFB);
    idle(1);

    // Reset after beat 5 aborts the op.
    run_op(1'b0, 13'd7, -1, 0, 1'b0, 5);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    m_active = 1'b0; exp_busy = 1'b0; exp_ov = 1'b0; exp_result = '0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result", result, 21'd0);
    chk("abort_ov", out_valid, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3);

    // Fresh op after reset, then a second start in the out_valid cycle.
    run_op(1'b1, 13'd1, -1, 0, 1'b0, NB);
    chk("lit_post_rst", result, 21'h1FFFFF);
    start = 1'b1; sus = 1'b0; in_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < NB; i++) begin
      in_valid = 1'b1; psum = 13'd2;
      tick();
      if (i < NB - 1) chk("b2b_no_ov_early", out_valid, 1'b0);
      if (i < NB - 1) chk("b2b_held", result, 21'h1FFFFF);
    end
    in_valid = 1'b0;
    chk("b2b_ov", out_valid, 1'b1);
    chk("lit_b2b", result, 21'd510);  chk("mdl_b2b", exp_result, 21'd510);
    idle(3);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_acc.md
Name: shift_acc

Overview:
- Bit-serial shift-accumulator at the output end of the DCIM adder tree.
- Consumes one adder-tree partial sum per input-bit plane, MSB plane first, and weights and combines them into the final multiply-accumulate result.
- Signed/unsigned mode is selected by `sus`, matching the adder tree's convention: 0 = unsigned, 1 = two's complement.
- In signed mode, the MSB plane carries negative weight.

Parameters:
- IN_WIDTH, 13, width of the partial sum from the adder tree (adder width + 1).
- NBITS, 8, number of input-bit planes (beats) per operation; must be ≥ 2.
- OUT_WIDTH, IN_WIDTH+NBITS, result width; sized so no final overflow can occur in either mode.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begins an operation; sampled only in IDLE.
- sus  input  1  mode, sampled with start: 0 = unsigned, 1 = signed.
- in_valid  input  1  psum beat valid.
- psum  input  IN_WIDTH  partial sum for the current bit plane.
- busy  output  1  high in ACC state.
- out_valid  output  1  one-cycle pulse: result is newly valid.
- result  output  OUT_WIDTH  accumulated result; held until the next completion.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, acc=0, beat count=0, sus_q=0, busy=0, out_valid=0, result=0. Reset asserted mid-operation aborts the operation with no out_valid.
- State IDLE:
  - start=1: latch sus into sus_q, clear acc and count, go to ACC next cycle.
  - in_valid is ignored in IDLE, including the start cycle.
- State ACC:
  - Each cycle with in_valid=1, psum is extended to OUT_WIDTH: sign-extended if sus_q=1, zero-extended if sus_q=0.
  - Beat 0 (MSB plane): acc <= ext(psum) if sus_q=0; acc <= -ext(psum) if sus_q=1.
  - Beats 1..NBITS-1: acc <= (acc<<1) + ext(psum).
  - All arithmetic is modulo 2^OUT_WIDTH; the final value is exact by construction.
  - count increments on each accepted beat.
  - in_valid=0: acc and count hold; bubbles are allowed at any point.
  - start=1 while in ACC is ignored; sus changes are ignored (sus_q is used).
- Completion:
  - On the accepted beat with count==NBITS-1, the final acc value is written to result on that same clock edge.
  - On that same edge, out_valid goes to 1 for exactly one cycle and the state returns to IDLE.
  - Latency: result and out_valid are visible the cycle after the last beat.
- Back-to-back operation: start may be asserted in the cycle out_valid=1, since the state is already IDLE. A new op begins without a dead cycle; result is held until that op completes.
- result interpretation: unsigned if the completing op had sus_q=0, two's complement if sus_q=1.
- busy = (state==ACC). out_valid is never high while busy is high.

Test Plan (defaults IN_WIDTH=13, NBITS=8, OUT_WIDTH=21):
- Unsigned: sus=0, 8 beats psum=1 -> one out_valid pulse the cycle after beat 8, result=255.
- Signed: sus=1, 8 beats psum=1 -> result=-1 (21'h1FFFFF).
- Signed: 8 beats psum=-1 -> result=+1.
- Signed: 8 beats psum=-4096 -> result=4096.
- Unsigned max: sus=0, 8 beats psum=13'h1FFF -> result=2088705, with no overflow.
- Bubbles and glitches:
  - sus=0, psum=13'd3 with in_valid low for 2 cycles between beats 3 and 4 -> result=765.
  - start and sus toggled mid-op -> ignored.
  - busy stays 1 throughout the op and out_valid pulses exactly once.
- Reset and back-to-back:
  - rst_n pulsed low after beat 5 -> busy=0, result=0, no out_valid.
  - A fresh op after reset (sus=1, psum=1) -> result=-1.
  - A second start asserted in the out_valid cycle -> the op completes 9 cycles later with the correct value.
